// File: rtl/exec_result_hilo_pkg.sv
// Shared definitions for the execute-stage result/HI-LO back end: funct codes, FSM states, widths.
// SIGNED_MULT_EN (when defined) enables the signed MULT funct in exec_result_hilo.
package exec_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int SHAMT_LIMIT = 32;

   localparam logic [5:0] SLL   = 6'b000000;
   localparam logic [5:0] SRL   = 6'b000010;
   localparam logic [5:0] MFHI  = 6'b010000;
   localparam logic [5:0] MFLO  = 6'b010010;
   localparam logic [5:0] MULT  = 6'b011000;
   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] ADD   = 6'b100000;
   localparam logic [5:0] SUB   = 6'b100010;
   localparam logic [5:0] AND   = 6'b100100;
   localparam logic [5:0] OR    = 6'b100101;
   localparam logic [5:0] SLT   = 6'b101010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/exec_result_hilo_if.sv
// Operation/result bundle between the upstream execute stage and exec_result_hilo.
interface exec_result_hilo_if import exec_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       Signal;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic [WIDTH-1:0] shift_in;
   logic [WIDTH-1:0] alu_in;
   logic             out_valid;
   logic [WIDTH-1:0] dataOut;
   logic             busy;

   modport master (
      output in_valid, Signal, dataA, dataB, shift_in, alu_in,
      input  in_ready, out_valid, dataOut, busy
   );

   modport slave (
      input  in_valid, Signal, dataA, dataB, shift_in, alu_in,
      output in_ready, out_valid, dataOut, busy
   );
endinterface

// File: rtl/exec_result_hilo_multu.sv
// Shift-add unsigned multiplier: one iteration per cycle, WIDTH iterations per product.
module multu_core import exec_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_prod;
   logic [CW-1:0]      r_count;
   logic               r_running;
   logic [WIDTH:0]     w_sum;

   // Carry out of the upper-half add becomes the new MSB after the shift.
   assign w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
   assign done    = r_running && (r_count == CW'(WIDTH-1));
   assign product = r_prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand   <= '0;
         r_prod    <= '0;
         r_count   <= '0;
         r_running <= 1'b0;
      end else if (start) begin
         r_mcand   <= a;
         r_prod    <= {{WIDTH{1'b0}}, b};
         r_count   <= '0;
         r_running <= 1'b1;
      end else if (r_running) begin
         r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
         r_count <= r_count + 1'b1;
         if (done) begin
            r_running <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/exec_result_hilo.sv
// Execute-stage back end: registers the selected result, owns HI/LO and the multi-cycle multiplier.
// Define SIGNED_MULT_EN to add the signed MULT funct.
module exec_result_hilo import exec_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input logic               clk,
   input logic               rst_n,
   exec_result_hilo_if.slave bus
);
   state_t             r_state;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_dataOut;
   logic               r_outValid;
   logic               r_busy;
   logic               r_inReady;

   logic               w_accept;
   logic               w_isMul;
   logic               w_done;
   logic [WIDTH-1:0]   w_mulA;
   logic [WIDTH-1:0]   w_mulB;
   logic [2*WIDTH-1:0] w_product;
   logic [2*WIDTH-1:0] w_prodFinal;

   assign w_accept = bus.in_valid && r_inReady;

`ifdef SIGNED_MULT_EN
   logic r_neg;
   logic w_signedOp;

   // Signed multiply runs the unsigned loop on magnitudes and fixes the sign at commit.
   assign w_signedOp  = (bus.Signal == MULT);
   assign w_isMul     = (bus.Signal == MULTU) || w_signedOp;
   assign w_mulA      = (w_signedOp && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
   assign w_mulB      = (w_signedOp && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
   assign w_prodFinal = r_neg ? -w_product : w_product;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_neg <= 1'b0;
      end else if (w_accept && w_isMul) begin
         r_neg <= w_signedOp && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
      end
   end
`else
   assign w_isMul     = (bus.Signal == MULTU);
   assign w_mulA      = bus.dataA;
   assign w_mulB      = bus.dataB;
   assign w_prodFinal = w_product;
`endif

   multu_core #(.WIDTH(WIDTH)) u_multu (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (w_accept && w_isMul),
      .a       (w_mulA),
      .b       (w_mulB),
      .done    (w_done),
      .product (w_product)
   );

   // in_ready stays low through DONE so a following MFHI/MFLO sees the committed HI/LO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_hi       <= '0;
         r_lo       <= '0;
         r_dataOut  <= '0;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
         r_inReady  <= 1'b1;
      end else begin
         r_outValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_isMul) begin
                     r_state   <= MUL;
                     r_busy    <= 1'b1;
                     r_inReady <= 1'b0;
                  end else begin
                     r_outValid <= 1'b1;
                     case (bus.Signal)
                        SLL, SRL:                r_dataOut <= bus.shift_in;
                        ADD, SUB, AND, OR, SLT:  r_dataOut <= bus.alu_in;
                        MFHI:                    r_dataOut <= r_hi;
                        MFLO:                    r_dataOut <= r_lo;
                        default:                 r_dataOut <= '0;
                     endcase
                  end
               end
            end
            MUL: begin
               if (w_done) begin
                  r_state    <= DONE;
                  r_busy     <= 1'b0;
                  r_outValid <= 1'b1;
                  r_dataOut  <= '0;
               end
            end
            DONE: begin
               r_hi      <= w_prodFinal[2*WIDTH-1:WIDTH];
               r_lo      <= w_prodFinal[WIDTH-1:0];
               r_state   <= IDLE;
               r_inReady <= 1'b1;
            end
            default: begin
               r_state   <= IDLE;
               r_busy    <= 1'b0;
               r_inReady <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.dataOut   = r_dataOut;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_exec_result_hilo.sv
// Scoreboard bench for exec_result_hilo: expected results queued at accept, checked on out_valid.
module tb_exec_result_hilo;
   import exec_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] expQ[$];
   logic [31:0] expVal;

   exec_result_hilo_if #(.WIDTH(32)) bus ();

   exec_result_hilo #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Compare one sampled value against a hand-computed constant.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Present one op at posedge+1, hold until accepted, queue its expected result.
   task automatic applyStimulus(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] sh, input logic [31:0] alu,
                                input logic [31:0] expOut, input bit pushExp);
      int waitCycles = 0;
      bus.Signal   = sig;
      bus.dataA    = a;
      bus.dataB    = b;
      bus.shift_in = sh;
      bus.alu_in   = alu;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && waitCycles < 100) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready %b, expected 1 within 100 cycles", bus.in_ready);
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         return;
      end
      if (pushExp) expQ.push_back(expOut);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Monitor: every out_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_out_valid: dataOut %h, expected no pulse", bus.dataOut);
         end else begin
            expVal = expQ.pop_front();
            if (bus.dataOut !== expVal) begin
               errors++;
               $display("[TB] FAIL dataOut: got %h, expected %h", bus.dataOut, expVal);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int busyCount;
      int guard;
      bus.in_valid = 1'b0;
      bus.Signal   = 6'd0;
      bus.dataA    = '0;
      bus.dataB    = '0;
      bus.shift_in = '0;
      bus.alu_in   = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_dataOut", bus.dataOut, 32'h0);
      checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
      checkOutput("reset_busy", {31'b0, bus.busy}, 32'h0);
      checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'h1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back shift/ALU/HI-LO reads.
      applyStimulus(SLL,  32'h0, 32'h0, 32'h0000_0F00, 32'hDEAD_BEEF, 32'h0000_0F00, 1'b1);
      applyStimulus(ADD,  32'h0, 32'h0, 32'h1111_1111, 32'h0000_0005, 32'h0000_0005, 1'b1);
      applyStimulus(SUB,  32'h0, 32'h0, 32'h1111_1111, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b1);
      applyStimulus(SRL,  32'h0, 32'h0, 32'h0000_1234, 32'h0000_0007, 32'h0000_1234, 1'b1);
      applyStimulus(SLT,  32'h0, 32'h0, 32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 1'b1);
      applyStimulus(MFHI, 32'h0, 32'h0, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0, 1'b1);
      applyStimulus(MFLO, 32'h0, 32'h0, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0, 1'b1);

      // Full-scale unsigned multiply: busy must last exactly WIDTH cycles.
      applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b1);
      busyCount = 0;
      guard = 0;
      @(negedge clk);
      while (bus.busy && guard < 100) begin
         busyCount++;
         guard++;
         @(negedge clk);
      end
      checkOutput("multu_busy_cycles", busyCount, 32'd32);
      @(posedge clk);
      #1;
      applyStimulus(MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b1);
      applyStimulus(MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0001, 1'b1);

      // Zero multiplicand.
      applyStimulus(MULTU, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b1);
      applyStimulus(MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      applyStimulus(MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

      // MFLO presented during MUL stalls, then returns the new LO.
      applyStimulus(MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
      checkOutput("stall_busy", {31'b0, bus.busy}, 32'h1);
      @(posedge clk);
      #1;
      applyStimulus(MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_000F, 1'b1);
      applyStimulus(MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

      // Undefined funct yields zero and leaves HI/LO alone.
      applyStimulus(6'b111111, 32'h0, 32'h0, 32'h1234_0000, 32'h0000_4321, 32'h0, 1'b1);
      applyStimulus(MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_000F, 1'b1);

`ifdef SIGNED_MULT_EN
      applyStimulus(MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0, 32'h0, 32'h0, 1'b1);
      applyStimulus(MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
      applyStimulus(MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFEB, 1'b1);
`else
      applyStimulus(MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0, 32'h0, 32'h0, 1'b1);
      applyStimulus(MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      applyStimulus(MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_000F, 1'b1);
`endif

      // Reset in the middle of a multiply aborts it and clears HI/LO.
      applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", {31'b0, bus.busy}, 32'h0);
      checkOutput("midreset_dataOut", bus.dataOut, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postreset_in_ready", {31'b0, bus.in_ready}, 32'h1);
      checkOutput("postreset_busy", {31'b0, bus.busy}, 32'h0);
      @(posedge clk);
      #1;
      applyStimulus(MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      applyStimulus(MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

      guard = 0;
      while (expQ.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d results outstanding, expected 0", expQ.size());
      end
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
